// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and the matching receiver).
// Contents: the line state machine encoding, the data width of a frame and the
// default oversampling ratio.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_if.sv
// Byte write channel into the UART transmitter.
//   wr_valid : producer has a byte on wr_data
//   wr_data  : byte to transmit
//   wr_ready : transmitter can accept a byte this cycle
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 wr_valid;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue ahead of the transmit shifter.
//   clk, rst_n : clock, synchronous active-low reset
//   push, wr_data : write request and byte (ignored when full)
//   pop, rd_data  : read request (ignored when empty) and current head byte
//   full, empty, count : occupancy, all derived from the registered count
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte queue.
//   clk, rst_n  : clock, synchronous active-low reset (aborts any frame, flushes queue)
//   baud_tick   : one-cycle oversample enable, OVERSAMPLE pulses per serial bit
//   wr          : byte write channel (uart_tx_if.slave)
//   bit_out     : registered serial line, idle high
//   busy        : a frame is on the line
//   fifo_count  : bytes queued, not counting the one in the shifter
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bit bit_idx on the line, LSB first
// STOP  | stop bit (1); at its end reload from the queue or go idle
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_tick,
    uart_tx_if.slave                      wr,
    output logic                          bit_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_e          state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 pop;

    assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

    // Reload happens straight from IDLE, or at the end of a stop bit so that
    // queued frames follow each other with no idle gap.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    // Ready comes from the registered count only; a same-cycle pop does not
    // open a slot until the next cycle.
    assign wr.wr_ready = !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr.wr_valid),
        .wr_data (wr.wr_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            bit_out  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if ((state != IDLE) && baud_tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        shift    <= fifo_head;
                        tick_cnt <= '0;
                        bit_out  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        bit_out <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BIT_LAST) begin
                            state   <= STOP;
                            bit_out <= 1'b1;
                        end else begin
                            // Shifter always presents the current bit at [0].
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            bit_out <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state   <= START;
                            shift   <= fifo_head;
                            bit_out <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_out <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios with random payloads,
// checked against a line-level frame model and a 16x-style sampling decoder.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int OS    = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic       bit_out;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_if wr();

    uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .wr         (wr),
        .bit_out    (bit_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         tick_div = 1;
    bit         line_q[$];
    logic [7:0] dec_bytes[$];
    int         dec_starts[$];
    int         framing_errs;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive baud_tick, advance past the edge, record the line.
    task automatic step();
        baud_tick = ((cyc % tick_div) == 0);
        @(posedge clk);
        #1;
        cyc++;
        line_q.push_back(bit_out);
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr.wr_valid = 1'b1;
        wr.wr_data  = b;
        step();
        wr.wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || fifo_count != 3'd0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_idle_in_time"}, 32'(n < budget), 32'd1);
        repeat (4) step();
    endtask

    // Expected line level of frame position k (0 = start, 1..8 = data, 9 = stop).
    function automatic bit frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Sampling decoder: find each falling edge, sample mid-bit.
    task automatic decode(input int bitlen);
        int         i;
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        framing_errs = 0;
        i = 1;
        while (i + 10*bitlen <= line_q.size()) begin
            if (line_q[i-1] == 1'b1 && line_q[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = line_q[i + (k+1)*bitlen + bitlen/2];
                if (line_q[i + bitlen/2] != 1'b0 || line_q[i + 9*bitlen + bitlen/2] != 1'b1)
                    framing_errs++;
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                i += 9*bitlen + bitlen/2;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_frames(input string tag, input int bitlen);
        int n;
        decode(bitlen);
        chk({tag, "_frame_count"}, 32'(dec_bytes.size()), 32'(exp_q.size()));
        chk({tag, "_framing"}, 32'(framing_errs), 32'd0);
        n = (dec_bytes.size() < exp_q.size()) ? dec_bytes.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_byte%0d", tag, k), 32'(dec_bytes[k]), 32'(exp_q[k]));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] first_byte;
        int         n;
        int         mism;
        int         zeros;
        int         trans[$];

        rst_n       = 1'b0;
        baud_tick   = 1'b0;
        wr.wr_valid = 1'b0;
        wr.wr_data  = 8'h00;
        tick_div    = 1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_bit_out", 32'(bit_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_wr_ready", 32'(wr.wr_ready), 32'd1);

        // Exact waveform of one 0x55 frame, baud_tick every clock
        line_q.delete();
        push_byte(8'h55);
        chk("w55_count_after_push", 32'(fifo_count), 32'd1);
        repeat (160) step();
        chk("w55_busy_at_160", 32'(busy), 32'd1);
        step();
        chk("w55_busy_falls", 32'(busy), 32'd0);
        chk("w55_idle_line", 32'(bit_out), 32'd1);
        for (int k = 0; k < 10; k++) begin
            mism = 0;
            for (int j = 0; j < OS; j++)
                if (line_q[1 + OS*k + j] != frame_bit(8'h55, k)) mism++;
            chk($sformatf("w55_pos%0d_mismatches", k), 32'(mism), 32'd0);
        end

        // Back-to-back frames with no idle gap
        line_q.delete();
        exp_q = '{8'hA3, 8'h0F};
        push_byte(8'hA3);
        push_byte(8'h0F);
        wait_idle("b2b", 1000);
        check_frames("b2b", OS);
        if (dec_starts.size() == 2)
            chk("b2b_no_gap", 32'(dec_starts[1] - dec_starts[0]), 32'(10*OS));
        else
            chk("b2b_two_starts", 32'(dec_starts.size()), 32'd2);

        // Overfill: six pushes, sixth rejected
        line_q.delete();
        exp_q.delete();
        wr.wr_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            wr.wr_data = b;
            if (k < 5) exp_q.push_back(b);
            step();
            if (k == 4) begin
                chk("full_count", 32'(fifo_count), 32'd4);
                chk("full_ready", 32'(wr.wr_ready), 32'd0);
            end
        end
        wr.wr_valid = 1'b0;
        chk("full_sixth_ignored", 32'(fifo_count), 32'd4);
        wait_idle("full", 4000);
        check_frames("full", OS);

        // Push held against a full queue across the pop cycle
        line_q.delete();
        exp_q.delete();
        wr.wr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            wr.wr_data = b;
            exp_q.push_back(b);
            step();
        end
        wr.wr_data = 8'($urandom);
        n = 0;
        while (fifo_count == 3'd4 && n < 400) begin
            step();
            n++;
        end
        chk("pp_pop_seen", 32'(n < 400), 32'd1);
        chk("pp_count_4_to_3", 32'(fifo_count), 32'd3);
        wr.wr_valid = 1'b0;
        wait_idle("pp", 4000);
        check_frames("pp", OS);

        // Slow baud: tick every 4 clocks
        tick_div = 4;
        line_q.delete();
        exp_q = '{8'h55};
        push_byte(8'h55);
        wait_idle("slow", 3000);
        check_frames("slow", OS*4);
        trans.delete();
        for (int i = 1; i < line_q.size(); i++)
            if (line_q[i] != line_q[i-1]) trans.push_back(i);
        chk("slow_transitions", 32'(trans.size()), 32'd10);
        if (trans.size() >= 10)
            for (int m = 1; m <= 8; m++)
                chk($sformatf("slow_bit%0d_len", m-1), 32'(trans[m+1] - trans[m]), 32'(OS*4));
        tick_div = 1;

        // Reset during data bit 3 with two bytes queued
        line_q.delete();
        first_byte = 8'($urandom);
        push_byte(first_byte);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        repeat (68) step();
        chk("mid_queued", 32'(fifo_count), 32'd2);
        chk("mid_bit3_on_line", 32'(bit_out), 32'(first_byte[3]));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_line_high", 32'(bit_out), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(wr.wr_ready), 32'd1);
        line_q.delete();
        repeat (400) step();
        zeros = 0;
        foreach (line_q[i]) if (line_q[i] == 1'b0) zeros++;
        chk("mid_no_more_frames", 32'(zeros), 32'd0);

        // Random payloads and baud rates
        for (int r = 0; r < 4; r++) begin
            tick_div = $urandom_range(1, 3);
            n = $urandom_range(1, 5);
            line_q.delete();
            exp_q.delete();
            wr.wr_valid = 1'b1;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                wr.wr_data = b;
                exp_q.push_back(b);
                step();
            end
            wr.wr_valid = 1'b0;
            wait_idle($sformatf("rnd%0d", r), n*10*OS*3 + 200);
            check_frames($sformatf("rnd%0d", r), OS*tick_div);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of bytes buffered ahead of the shifter (power of two, 2..16).
REQ-002 Parameter OVERSAMPLE, default 16, SHALL set the number of baud_tick pulses per serial bit.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 baud_tick  input  1  SHALL be the oversample enable; one-cycle pulse, OVERSAMPLE pulses per bit.
REQ-006 wr_valid  input  1  SHALL indicate that wr_data holds a byte to queue.
REQ-007 wr_data  input  8  SHALL be the byte to transmit.
REQ-008 wr_ready  output  1  SHALL be high when the FIFO can accept a byte (count < FIFO_DEPTH).
REQ-009 bit_out  output  1  SHALL be the serial line; idle high.
REQ-010 busy  output  1  SHALL be high while a frame is on the line (state != IDLE).
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  SHALL report the number of queued bytes, excluding the byte in the shifter.

Function
REQ-012 A byte SHALL be queued on a rising edge where wr_valid && wr_ready; wr_valid while !wr_ready SHALL be ignored, with no state change.
REQ-013 wr_ready SHALL derive from registered fifo_count only; a pop in the same cycle SHALL NOT raise wr_ready for that cycle.
REQ-014 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1, each held for exactly OVERSAMPLE baud_ticks.
REQ-015 The state machine SHALL have states IDLE, START, DATA, STOP.
REQ-016 IDLE -> START SHALL occur on the first clk edge with FIFO non-empty; on that edge the FIFO head SHALL be popped into the shift register, the tick counter cleared, and bit_out driven 0.
REQ-017 START -> DATA SHALL occur when the tick counter reaches OVERSAMPLE-1 on a baud_tick; bit_out SHALL then present shift[0].
REQ-018 In DATA, each bit SHALL end when the tick counter reaches OVERSAMPLE-1 on a baud_tick; the bit index SHALL advance 0..7, and after bit 7 the state SHALL go to STOP with bit_out = 1.
REQ-019 STOP SHALL end after OVERSAMPLE ticks: if the FIFO is non-empty, go directly to START with a pop (back-to-back frames, no idle gap); otherwise go to IDLE.
REQ-020 The tick counter SHALL advance only on baud_tick and SHALL wrap to 0 at OVERSAMPLE-1; cycles without baud_tick SHALL hold all state except the FIFO.
REQ-021 bit_out SHALL be registered (no combinational glitch) and SHALL equal 1 in IDLE and STOP.
REQ-022 A push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 On rst_n = 0 at a clk edge: state = IDLE, bit_out = 1, busy = 0, fifo_count = 0, wr_ready = 1, counters = 0.
REQ-025 Reset mid-frame SHALL abort the frame (line returns high on the next cycle) and SHALL discard all queued bytes.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP), DATA_BITS = 8, and the default OVERSAMPLE = 16, shared with the receiver.
REQ-027 The FIFO SHALL be a sub-module uart_tx_fifo (push/pop/full/empty/count); uart_tx SHALL contain only the FSM, counters and shifter.

Verification
REQ-028 After reset, push 0x55 with baud_tick every clk: bit_out = 0 for 16 cycles, then 1,0,1,0,1,0,1,0 (16 cycles each), then 1 for 16; busy falls after 160 cycles.
REQ-029 Push 0xA3 then 0x0F back-to-back: two frames with no idle gap; a 16x sampler recovers 0xA3, 0x0F.
REQ-030 Push 5 bytes while IDLE with FIFO_DEPTH = 4: the first pops to the shifter, the next 4 fill the FIFO, wr_ready = 0 and fifo_count = 4; a 6th push is ignored and exactly 5 frames are sent.
REQ-031 baud_tick once every 4 clk: each bit lasts 64 clk, and the frame content is unchanged.
REQ-032 Assert rst_n = 0 for 1 cycle during DATA bit 3 with 2 bytes queued: bit_out = 1 on the next cycle, fifo_count = 0, and no further frames.
REQ-033 At full, push and pop in the same cycle: the push is rejected (wr_ready = 0) and fifo_count goes from 4 to 3.
